bip_control_unit: RTL and testbench

- Multi-cycle instruction sequencer that sits directly upstream of the accumulator datapath.
- Holds the program counter and fetches 16-bit instructions from a synchronous program memory.
- Decodes each instruction and drives the datapath controls (SelA, SelB, WrAcc, Op, Addr) and the data-memory strobes (WrRam, RdRam).
- Instruction format: opcode = Instr[15:11], operand = Instr[10:0].

---
 rtl/bip_control_unit.sv | 169 ++++++++++++++++
 tb/tb_bip_control_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - multi-cycle instruction sequencer for the BIP accumulator datapath
//
// Fetches 16-bit instructions from a synchronous program memory. Each one is
// decoded as opcode = Instr[15:11] and operand = Instr[10:0]. The unit then
// drives the accumulator datapath controls and the data-memory strobes as a
// Moore decode of the state and the instruction register.
//
// Optional feature: define BIP_CYCLE_COUNT_EN to build the saturating
// busy-cycle counter. When it is not defined, Cycles is tied to zero.
//
// Ports:
//   clk      system clock, rising edge
//   Clear    synchronous active-low reset
//   Start    begin execution from PC=0 (honoured only in IDLE)
//   Instr    program memory read data, valid one cycle after Addr_PM
//   Addr_PM  program memory address (the PC)
//   Addr     operand field, non-zero only in EXEC and MEM
//   SelA     accumulator mux select: 0=ALU, 1=sign-extended operand, 2=data memory
//   SelB     ALU operand B select: 0=sign-extended operand, 1=data memory
//   WrAcc    accumulator write enable
//   Op       ALU operation: 1=add, 0=subtract
//   WrRam    data memory write strobe
//   RdRam    data memory read strobe
//   Busy     high in FETCH, DECODE, EXEC and MEM
//   Halted   high in HALT
//   Cycles   busy-cycle count

module bip_control_unit #(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5
) (
    input  logic            clk,
    input  logic            Clear,
    input  logic            Start,
    input  logic [15:0]     Instr,
    output logic [PC_W-1:0] Addr_PM,
    output logic [10:0]     Addr,
    output logic [1:0]      SelA,
    output logic            SelB,
    output logic            WrAcc,
    output logic            Op,
    output logic            WrRam,
    output logic            RdRam,
    output logic            Busy,
    output logic            Halted,
    output logic [31:0]     Cycles
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

    logic [2:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [OPC_W-1:0] ir_opc;
    logic [OPC_W-1:0] instr_opc;
    logic             ir_is_mem;

    assign ir_opc    = ir_q[15 -: OPC_W];
    assign instr_opc = Instr[15 -: OPC_W];
    // These opcodes read data memory and need the extra MEM cycle.
    assign ir_is_mem = (ir_opc == OP_LD) || (ir_opc == OP_ADD) || (ir_opc == OP_SUB);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:   if (Start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // The decision uses the live memory word, because IR is loaded on this same edge.
                ir_d = Instr;
                if (instr_opc == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = ir_is_mem ? S_MEM : S_FETCH;
            S_MEM:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        SelA  = 2'd0;
        SelB  = 1'b0;
        Op    = 1'b0;
        WrAcc = 1'b0;
        WrRam = 1'b0;
        RdRam = 1'b0;
        case (state_q)
            S_EXEC: begin
                case (ir_opc)
                    OP_STO:  WrRam = 1'b1;
                    OP_LD:   RdRam = 1'b1;
                    OP_LDI:  begin SelA = 2'd1; WrAcc = 1'b1; end
                    OP_ADD:  RdRam = 1'b1;
                    OP_ADDI: begin Op = 1'b1; WrAcc = 1'b1; end
                    OP_SUB:  RdRam = 1'b1;
                    OP_SUBI: WrAcc = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                // The read strobe stays high so the memory output remains valid for the write-back.
                RdRam = 1'b1;
                case (ir_opc)
                    OP_LD:   begin SelA = 2'd2; WrAcc = 1'b1; end
                    OP_ADD:  begin SelB = 1'b1; Op = 1'b1; WrAcc = 1'b1; end
                    OP_SUB:  begin SelB = 1'b1; WrAcc = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign Addr    = (state_q == S_EXEC || state_q == S_MEM) ? ir_q[10:0] : 11'd0;
    assign Addr_PM = pc_q;
    assign Busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_MEM);
    assign Halted  = (state_q == S_HALT);

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk) begin
        if (!Clear) begin
            cycles_q <= '0;
        end else if (Busy && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign Cycles = cycles_q;
`else
    assign Cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - directed self-checking bench for bip_control_unit

module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        Clear = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Instr;
    logic [10:0] Addr_PM;
    logic [10:0] Addr;
    logic [1:0]  SelA;
    logic        SelB, WrAcc, Op, WrRam, RdRam, Busy, Halted;
    logic [31:0] Cycles;

`ifdef BIP_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    bip_control_unit #(.PC_W(11), .OPC_W(5)) dut (
        .clk(clk), .Clear(Clear), .Start(Start), .Instr(Instr),
        .Addr_PM(Addr_PM), .Addr(Addr), .SelA(SelA), .SelB(SelB),
        .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam),
        .Busy(Busy), .Halted(Halted), .Cycles(Cycles)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:2047];
    always @(posedge clk) Instr <= rom[Addr_PM];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {Halted, Busy, RdRam, WrRam, Op, WrAcc, SelB, SelA[1:0]}
    function automatic logic [8:0] ctl_now();
        return {Halted, Busy, RdRam, WrRam, Op, WrAcc, SelB, SelA};
    endfunction

    localparam logic [8:0] EXP_SL [0:11] = '{9'h080, 9'h080, 9'h089, 9'h080, 9'h080, 9'h098,
                                             9'h080, 9'h080, 9'h0A0, 9'h080, 9'h080, 9'h100};
    localparam logic [8:0] EXP_MEM [0:10] = '{9'h080, 9'h080, 9'h0C0, 9'h0CA, 9'h080, 9'h080,
                                              9'h0C0, 9'h0CC, 9'h080, 9'h080, 9'h100};
    localparam logic [8:0] EXP_ILL [0:5] = '{9'h080, 9'h080, 9'h080, 9'h080, 9'h080, 9'h100};

    logic [8:0]  ctl_tr  [0:15];
    logic [10:0] addr_tr [0:15];
    logic [10:0] pm_tr   [0:15];
    logic [31:0] cyc_tr  [0:15];

    task automatic load_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int k = 0; k < 2048; k++) rom[k] = 16'h0000;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
    endtask

    task automatic do_reset();
        @(negedge clk) Clear = 1'b0;
        @(negedge clk) Clear = 1'b1;
    endtask

    // Pulses Start from IDLE and records n cycles. Index 0 is the FETCH of address 0.
    task automatic run_prog(input int n);
        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            ctl_tr[i]  = ctl_now();
            addr_tr[i] = Addr;
            pm_tr[i]   = Addr_PM;
            cyc_tr[i]  = Cycles;
        end
    endtask

    int          bad_pm, bad_ctl;
    logic [10:0] pm_last, pm_wrap;

    initial begin
        for (int k = 0; k < 2048; k++) rom[k] = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_ctl", 32'(ctl_now()), 32'h0);
        check_val("rst_pm", 32'(Addr_PM), 32'h0);
        check_val("rst_addr", 32'(Addr), 32'h0);
        check_val("rst_cycles", Cycles, 32'h0);
        Clear = 1'b1;

        // Straight-line program: LDI 5, ADDI 3, STO 7, HLT
        load_rom(16'h1805, 16'h2803, 16'h0807);
        run_prog(12);
        for (int i = 0; i < 12; i++)
            check_val($sformatf("sl_ctl[%0d]", i), 32'(ctl_tr[i]), 32'(EXP_SL[i]));
        check_val("sl_pm0", 32'(pm_tr[0]), 32'h0);
        check_val("sl_addr_fetch", 32'(addr_tr[0]), 32'h0);
        check_val("sl_addr_ldi", 32'(addr_tr[2]), 32'h5);
        check_val("sl_addr_sto", 32'(addr_tr[8]), 32'h7);
        check_val("sl_cycles", cyc_tr[11], CNT_EN ? 32'd11 : 32'd0);

        // After a halt, Start is ignored until Clear.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk) Start = 1'b1;
            @(negedge clk) Start = 1'b0;
            check_val($sformatf("hold_ctl[%0d]", k), 32'(ctl_now()), 32'h100);
            check_val($sformatf("hold_pm[%0d]", k), 32'(Addr_PM), 32'h3);
        end
        check_val("hold_cycles", Cycles, CNT_EN ? 32'd11 : 32'd0);
        @(negedge clk) Clear = 1'b0;
        @(negedge clk);
        check_val("hold_clear_ctl", 32'(ctl_now()), 32'h0);
        check_val("hold_clear_pm", 32'(Addr_PM), 32'h0);
        Clear = 1'b1;

        // Memory ops: LD 9, SUB 4, HLT
        load_rom(16'h1009, 16'h3004, 16'h0000);
        run_prog(11);
        for (int i = 0; i < 11; i++)
            check_val($sformatf("mem_ctl[%0d]", i), 32'(ctl_tr[i]), 32'(EXP_MEM[i]));
        check_val("mem_addr_ld_e", 32'(addr_tr[2]), 32'd9);
        check_val("mem_addr_ld_m", 32'(addr_tr[3]), 32'd9);
        check_val("mem_addr_sub_e", 32'(addr_tr[6]), 32'd4);
        check_val("mem_addr_sub_m", 32'(addr_tr[7]), 32'd4);
        check_val("mem_cycles", cyc_tr[10], CNT_EN ? 32'd10 : 32'd0);

        // Illegal opcode then HLT
        do_reset();
        load_rom(16'hF800, 16'h0000, 16'h0000);
        run_prog(6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("ill_ctl[%0d]", i), 32'(ctl_tr[i]), 32'(EXP_ILL[i]));
        check_val("ill_pm_fetch2", 32'(pm_tr[3]), 32'h1);
        check_val("ill_pm_halt", 32'(pm_tr[5]), 32'h1);

        // Clear in the MEM cycle of an ADD
        do_reset();
        load_rom(16'h2002, 16'h0000, 16'h0000);
        run_prog(4);
        check_val("midrst_mem_ctl", 32'(ctl_tr[3]), 32'h0DC);
        check_val("midrst_mem_addr", 32'(addr_tr[3]), 32'h2);
        Clear = 1'b0;
        @(negedge clk);
        check_val("midrst_ctl", 32'(ctl_now()), 32'h0);
        check_val("midrst_pm", 32'(Addr_PM), 32'h0);
        check_val("midrst_addr", 32'(Addr), 32'h0);
        check_val("midrst_cycles", Cycles, 32'h0);
        Clear = 1'b1;
        run_prog(1);
        check_val("midrst_restart_pm", 32'(pm_tr[0]), 32'h0);
        check_val("midrst_restart_ctl", 32'(ctl_tr[0]), 32'h080);

        // PC wrap over 2048 NOPs, with a stray Start while busy
        do_reset();
        for (int k = 0; k < 2048; k++) rom[k] = 16'h4000;
        bad_pm  = 0;
        bad_ctl = 0;
        pm_last = '0;
        pm_wrap = 11'h7FF;
        run_prog(1);
        for (int i = 0; i <= 2048; i++) begin
            if (i > 0) @(negedge clk);
            if (Addr_PM !== 11'(i)) bad_pm++;
            if (ctl_now() !== 9'h080) bad_ctl++;
            if (i == 2047) pm_last = Addr_PM;
            if (i == 2048) begin
                pm_wrap = Addr_PM;
                break;
            end
            @(negedge clk);
            if (i == 100) Start = 1'b1;
            if (ctl_now() !== 9'h080) bad_ctl++;
            @(negedge clk);
            Start = 1'b0;
            if (ctl_now() !== 9'h080) bad_ctl++;
        end
        check_val("wrap_pm_seq", 32'(bad_pm), 32'd0);
        check_val("wrap_ctl_seq", 32'(bad_ctl), 32'd0);
        check_val("wrap_pm_last", 32'(pm_last), 32'h7FF);
        check_val("wrap_pm_zero", 32'(pm_wrap), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
